mem_access_ctrl: RTL and testbench

- Sequences data-memory accesses for the MEM stage.
- Consumes the MEM-stage control bundle (mem_enable, mem_rw, mem_size, mem_se) plus effective address and store data.
- Runs a req/ack handshake to a 32-bit word-wide data memory with byte enables, and stalls the pipeline until the access completes.
- Performs big-endian byte/halfword lane steering, sign/zero extension, alignment checking and an ack timeout.

---
 rtl/mem_access_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   MEM-stage data-memory access sequencer. Takes the MEM-stage control
//   bundle plus effective address and store data, runs a req/ack handshake
//   to a 32-bit word-wide big-endian data memory with byte enables, and
//   stalls the pipeline until the access completes, fails alignment, or
//   times out waiting for dm_ack.
//
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   mem_enable, mem_rw    access request, 0 = load / 1 = store
//   mem_size, mem_se      00 byte, 01 half, 1x word; sign-extend loads
//   addr, store_data      effective byte address, store operand
//   load_data             extended load result, valid in DONE only
//   stall                 holds IF..MEM pipeline registers
//   addr_error, timeout   one-cycle pulses in DONE
//   dm_req, dm_we         memory request / write enable (held during BUSY)
//   dm_addr, dm_be        word address, byte enables (bit3 = bits[31:24])
//   dm_wdata              lane-replicated store data
//   dm_rdata, dm_ack      memory read data / completion
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_enable,
    input  logic        mem_rw,
    input  logic [1:0]  mem_size,
    input  logic        mem_se,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        addr_error,
    output logic        timeout,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [31:0] addr_q;
    logic        rw_q;
    logic [1:0]  size_q;
    logic        se_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [7:0]  cnt_q;
    logic [31:0] load_q;
    logic        addr_err_q;
    logic        timeout_q;

    logic        misaligned;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ext_data;
    logic        busy;

    // Alignment check on the incoming request
    always_comb begin
        misaligned = 1'b0;
        case (mem_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr[0];
            default: misaligned = |addr[1:0];
        endcase
    end

    // Big-endian store steering: byte offset 0 is the MSB lane
    always_comb begin
        be_n    = 4'b1111;
        wdata_n = store_data;
        case (mem_size)
            2'b00: begin
                wdata_n = {4{store_data[7:0]}};
                case (addr[1:0])
                    2'b00:   be_n = 4'b1000;
                    2'b01:   be_n = 4'b0100;
                    2'b10:   be_n = 4'b0010;
                    default: be_n = 4'b0001;
                endcase
            end
            2'b01: begin
                wdata_n = {2{store_data[15:0]}};
                be_n    = addr[1] ? 4'b0011 : 4'b1100;
            end
            default: begin
                be_n    = 4'b1111;
                wdata_n = store_data;
            end
        endcase
        // Loads always fetch the full word; lane selection happens on return
        if (!mem_rw) begin
            be_n = 4'b1111;
        end
    end

    // Lane extraction and extension of returning read data
    always_comb begin
        case (addr_q[1:0])
            2'b00:   lane_b = dm_rdata[31:24];
            2'b01:   lane_b = dm_rdata[23:16];
            2'b10:   lane_b = dm_rdata[15:8];
            default: lane_b = dm_rdata[7:0];
        endcase
        lane_h = addr_q[1] ? dm_rdata[15:0] : dm_rdata[31:16];
        case (size_q)
            2'b00:   ext_data = {{24{se_q & lane_b[7]}}, lane_b};
            2'b01:   ext_data = {{16{se_q & lane_h[15]}}, lane_h};
            default: ext_data = dm_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            size_q     <= '0;
            se_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            load_q     <= '0;
            addr_err_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            // Result and status pulses live for the single DONE cycle only
            load_q     <= '0;
            addr_err_q <= 1'b0;
            timeout_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_enable) begin
                        addr_q  <= addr;
                        rw_q    <= mem_rw;
                        size_q  <= mem_size;
                        se_q    <= mem_se;
                        be_q    <= be_n;
                        wdata_q <= wdata_n;
                        cnt_q   <= '0;
                        if (misaligned) begin
                            state      <= DONE;
                            addr_err_q <= 1'b1;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // An ack in the final allowed cycle still completes normally
                    if (dm_ack) begin
                        state  <= DONE;
                        load_q <= rw_q ? '0 : ext_data;
                    end else if (cnt_q == CNT_LAST) begin
                        state     <= DONE;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy       = (state == BUSY);
    assign dm_req     = busy;
    assign dm_we      = busy & rw_q;
    assign dm_addr    = busy ? {addr_q[31:2], 2'b00} : '0;
    assign dm_be      = busy ? be_q : '0;
    assign dm_wdata   = busy ? wdata_q : '0;
    assign load_data  = load_q;
    assign addr_error = addr_err_q;
    assign timeout    = timeout_q;
    // A new request stalls in its own IDLE cycle; reset overrides everything
    assign stall      = !reset && (busy || ((state == IDLE) && mem_enable));

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    localparam int TMO = 16;

    logic        clk;
    logic        reset;
    logic        mem_enable;
    logic        mem_rw;
    logic [1:0]  mem_size;
    logic        mem_se;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        stall;
    logic        addr_error;
    logic        timeout;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_enable (mem_enable),
        .mem_rw     (mem_rw),
        .mem_size   (mem_size),
        .mem_se     (mem_se),
        .addr       (addr),
        .store_data (store_data),
        .load_data  (load_data),
        .stall      (stall),
        .addr_error (addr_error),
        .timeout    (timeout),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_be      (dm_be),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata),
        .dm_ack     (dm_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Expected values for the current cycle, written by the driver
    logic        chk_en = 1'b0;
    logic        e_stall, e_req, e_we, e_aerr, e_tmo;
    logic        e_busy, e_wd_en, e_ld_en, e_lit_bus, e_lit_ld;
    logic [31:0] e_addr, e_wd, e_ld, lit_wd_v, lit_ld_v;
    logic [3:0]  e_be, lit_be_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic clear_exp();
        e_stall = 0; e_req = 0; e_we = 0; e_aerr = 0; e_tmo = 0;
        e_busy = 0; e_wd_en = 0; e_ld_en = 0; e_lit_bus = 0; e_lit_ld = 0;
        e_addr = '0; e_wd = '0; e_ld = '0; e_be = '0;
    endtask

    // Behavioural model of the access rules
    function automatic logic m_misal(input logic [1:0] size, input logic [31:0] a);
        if (size == 2'b00) return 1'b0;
        if (size == 2'b01) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    function automatic logic [3:0] m_be(input logic rw, input logic [1:0] size, input logic [31:0] a);
        if (!rw || size[1]) return 4'hF;
        if (size == 2'b00) return 4'(8 >> a[1:0]);
        return a[1] ? 4'h3 : 4'hC;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] size, input logic [31:0] sd);
        if (size == 2'b00) return (sd & 32'hFF) * 32'h01010101;
        if (size == 2'b01) return (sd & 32'hFFFF) * 32'h00010001;
        return sd;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic se,
                                           input logic [31:0] a, input logic [31:0] rd);
        int sh;
        logic [31:0] v;
        if (size == 2'b00) begin
            sh = 8 * (3 - int'(a[1:0]));
            v = (rd >> sh) & 32'hFF;
            if (se && v[7]) v = v | 32'hFFFFFF00;
        end else if (size == 2'b01) begin
            sh = 16 * (1 - int'(a[1]));
            v = (rd >> sh) & 32'hFFFF;
            if (se && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // Single compare process: every cycle at negedge while enabled
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", {31'd0, stall}, {31'd0, e_stall});
            chk("dm_req", {31'd0, dm_req}, {31'd0, e_req});
            chk("dm_we", {31'd0, dm_we}, {31'd0, e_we});
            chk("addr_error", {31'd0, addr_error}, {31'd0, e_aerr});
            chk("timeout", {31'd0, timeout}, {31'd0, e_tmo});
            if (e_busy) begin
                chk("dm_addr", dm_addr, e_addr);
                chk("dm_be", {28'd0, dm_be}, {28'd0, e_be});
            end
            if (e_wd_en) chk("dm_wdata", dm_wdata, e_wd);
            if (e_ld_en) chk("load_data", load_data, e_ld);
            if (e_lit_bus) begin
                chk("lit_be", {28'd0, dm_be}, {28'd0, lit_be_v});
                chk("lit_wdata", dm_wdata, lit_wd_v);
            end
            if (e_lit_ld) chk("lit_load", load_data, lit_ld_v);
        end
    end

    // One access: request cycle, BUSY/DONE per the rules, then one IDLE cycle.
    // ack_cyc = BUSY cycle on which dm_ack is raised (0 = never).
    task automatic access(input logic rw, input logic [1:0] size, input logic se,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                          input int ack_cyc, input logic lit_en, input logic [31:0] lit_ld,
                          input logic [3:0] lit_be, input logic [31:0] lit_wd);
        int  n;
        bit  done;
        bit  timed;
        @(posedge clk); #1;
        mem_enable = 1; mem_rw = rw; mem_size = size; mem_se = se;
        addr = a; store_data = sd; dm_ack = 0; dm_rdata = $urandom;
        clear_exp();
        e_stall = 1;
        chk_en = 1;
        if (m_misal(size, a)) begin
            @(posedge clk); #1;
            // DONE: request inputs must be ignored
            mem_enable = 1; mem_rw = ~rw; addr = $urandom; dm_ack = 1;
            clear_exp();
            e_aerr = 1;
        end else begin
            n = 0;
            done = 0;
            while (!done) begin
                @(posedge clk); #1;
                n++;
                // Pipeline inputs wander while BUSY; DUT must use latched copy
                addr = $urandom; store_data = $urandom; mem_size = 2'($urandom);
                dm_ack = (n == ack_cyc);
                dm_rdata = dm_ack ? rd : $urandom;
                clear_exp();
                e_stall = 1; e_req = 1; e_we = rw; e_busy = 1;
                e_addr = {a[31:2], 2'b00};
                e_be = m_be(rw, size, a);
                e_wd_en = rw;
                e_wd = m_wd(size, sd);
                if (lit_en && rw) begin
                    e_lit_bus = 1; lit_be_v = lit_be; lit_wd_v = lit_wd;
                end
                if (n == ack_cyc || n == TMO) done = 1;
            end
            timed = (ack_cyc == 0 || ack_cyc > TMO);
            @(posedge clk); #1;
            mem_enable = 1; addr = $urandom; dm_ack = 1; dm_rdata = $urandom;
            clear_exp();
            e_tmo = timed;
            if (!rw || timed) begin
                e_ld_en = 1;
                e_ld = timed ? 32'd0 : m_load(size, se, a, rd);
            end
            if (lit_en && !rw) begin
                e_lit_ld = 1; lit_ld_v = lit_ld;
            end
        end
        @(posedge clk); #1;
        // IDLE: a stray ack must be ignored
        mem_enable = 0; dm_ack = 1;
        clear_exp();
    endtask

    task automatic reset_mid_busy();
        @(posedge clk); #1;
        chk_en = 0;
        mem_enable = 1; mem_rw = 0; mem_size = 2'b10; mem_se = 0;
        addr = 32'h300; dm_ack = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_pre_req", {31'd0, dm_req}, 32'd1);
        reset = 1;
        #1;
        chk("rst_req", {31'd0, dm_req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_be", {28'd0, dm_be}, 32'd0);
        chk("rst_addr", dm_addr, 32'd0);
        chk("rst_load", load_data, 32'd0);
        @(posedge clk); #1;
        reset = 0; mem_enable = 0; dm_ack = 0;
        @(negedge clk);
        chk("post_rst_stall", {31'd0, stall}, 32'd0);
        chk("post_rst_req", {31'd0, dm_req}, 32'd0);
        chk("post_rst_pulse", {30'd0, addr_error, timeout}, 32'd0);
    endtask

    initial begin
        reset = 1; mem_enable = 1; mem_rw = 0; mem_size = 0; mem_se = 0;
        addr = 0; store_data = 0; dm_rdata = 0; dm_ack = 0;
        clear_exp();
        lit_wd_v = '0; lit_ld_v = '0; lit_be_v = '0;
        #1;
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_req", {31'd0, dm_req}, 32'd0);
        chk("reset_we", {31'd0, dm_we}, 32'd0);
        chk("reset_load", load_data, 32'd0);
        chk("reset_pulses", {30'd0, addr_error, timeout}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 0; mem_enable = 0;

        // word load, ack on 3rd BUSY cycle
        access(0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 3, 1, 32'hDEADBEEF, 4'h0, 32'h0);
        // signed / unsigned byte load at offset 3
        access(0, 2'b00, 1, 32'h103, 32'h0, 32'h123456F0, 1, 1, 32'hFFFFFFF0, 4'h0, 32'h0);
        access(0, 2'b00, 0, 32'h103, 32'h0, 32'h123456F0, 1, 1, 32'h000000F0, 4'h0, 32'h0);
        // halfword store to upper-address half
        access(1, 2'b01, 0, 32'h202, 32'hAAAA1234, 32'h0, 2, 1, 32'h0, 4'b0011, 32'h12341234);
        // misaligned word load
        access(0, 2'b10, 0, 32'h101, 32'h0, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0);
        // no ack: timeout after TMO BUSY cycles
        access(0, 2'b10, 1, 32'h400, 32'h0, 32'h0, 0, 1, 32'h0, 4'h0, 32'h0);
        // ack on the final allowed cycle wins over timeout
        access(0, 2'b01, 1, 32'h402, 32'h0, 32'h55AA00FF, TMO, 1, 32'h000000FF, 4'h0, 32'h0);
        // byte stores at all four offsets
        for (int i = 0; i < 4; i++) begin
            access(1, 2'b00, 0, 32'h800 + 32'(i), 32'h123456A5, 32'h0, 1, 1, 32'h0,
                   4'(8 >> i), 32'hA5A5A5A5);
        end
        // signed halfword load from lower-address half
        access(0, 2'b01, 1, 32'h500, 32'h0, 32'h80011234, 2, 1, 32'hFFFF8001, 4'h0, 32'h0);
        // misaligned halfword store, size 11 word store, misaligned size 11
        access(1, 2'b01, 0, 32'h203, 32'hFFFF, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0);
        access(1, 2'b11, 0, 32'h600, 32'hCAFEF00D, 32'h0, 2, 1, 32'h0, 4'hF, 32'hCAFEF00D);
        access(0, 2'b11, 0, 32'h602, 32'h0, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0);

        // reset during BUSY, then a clean byte store
        reset_mid_busy();
        access(1, 2'b00, 0, 32'h701, 32'h0000005A, 32'h0, 1, 1, 32'h0, 4'b0100, 32'h5A5A5A5A);

        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
